pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-address controller for the 8-bit program counter register. Every cycle it selects the value driven onto the PC register's `PCin`. The choices are sequential increment, jump, conditional branch on the zero flag, call, return, hold, or halt. It owns a small return-address stack and a run/halt/error state machine. It sits between the decoder/control unit and the PC register, and takes the register's `PCout` back as `pc_cur`.

## Interface
- `AW`, 8: address width; matches the PC register.
- `DEPTH`, 4: return-stack entries, 2..16.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pc_cur` input AW: current PC, from the PC register output.
- `cmd_valid` input 1: `cmd` is meaningful this cycle.
- `cmd` input 3: 0 INC, 1 JMP, 2 BZ, 3 BNZ, 4 CALL, 5 RET, 6 HALT, 7 HOLD.
- `target` input AW: jump, branch or call destination.
- `zflag` input 1: ALU zero flag.
- `stall` input 1: freeze PC and internal state.
- `resume` input 1: leave HALT.
- `pc_next` output AW: drives the PC register's `PCin`.
- `halted` output 1: state is HALT.
- `err` output 1: state is ERR (stack overflow or underflow).
- `sp` output $clog2(DEPTH+1): current stack occupancy.

## Operation
- States: RUN, HALT, ERR. Reset enters RUN with `sp`=0 and stack contents don't-care.
- `pc_next` is combinational from state, inputs and stack top.
- While `rst`=1: `pc_next`=0, `halted`=0, `err`=0, `sp`=0.
- RUN with `stall`=1: `pc_next`=`pc_cur`; no state or stack change. `stall` beats `cmd`.
- RUN with `cmd_valid`=0: treated as INC.
- RUN, `stall`=0, `cmd_valid`=1:
  - INC: `pc_cur`+1, modulo 2^AW (0xFF wraps to 0x00).
  - JMP: `target`.
  - BZ: `target` if `zflag`, else `pc_cur`+1.
  - BNZ: `target` if not `zflag`, else `pc_cur`+1.
  - CALL: push `pc_cur`+1 (wrapped) and output `target`. If `sp`=DEPTH: no push, `pc_next`=`pc_cur`, go to ERR.
  - RET: pop and output the popped value. If `sp`=0: `pc_next`=`pc_cur`, go to ERR.
  - HALT: `pc_next`=`pc_cur`, go to HALT.
  - HOLD: `pc_next`=`pc_cur`; state unchanged.
- HALT: `pc_next`=`pc_cur`; commands ignored. `resume`=1 with `stall`=0 returns to RUN next edge; the first RUN cycle obeys `cmd`. `stall` blocks `resume`.
- ERR: `pc_next`=`pc_cur`, `err`=1. Only `rst` exits.

## Timing
- Zero-cycle combinational path from `cmd`/`target`/`zflag`/`stall` to `pc_next`. The PC register captures it on the same edge.
- Stack, `sp` and state update on that same edge. A RET immediately after a CALL returns the address pushed by that CALL.
- Effective branch latency is 1 clock: the new `pc_cur` is visible the cycle after the command.
- `halted`, `err` and `sp` are registered-state decodes, valid the cycle after the causing edge.
- `rst` asserted mid-operation clears everything asynchronously. Deassertion is taken synchronously by the downstream PC register.

## Configuration
- `PC_SEQ_STACK_EN` defined: the return stack is instantiated and CALL/RET behave as above.
- `PC_SEQ_STACK_EN` undefined: no stack.
  - CALL acts as JMP.
  - RET acts as INC.
  - `sp` is tied to 0.
  - Overflow/underflow cannot occur, so ERR is reachable only by no path; `err` is tied to 0.

## Structure
- `pc_seq_pkg`: `cmd` encoding constants (CMD_INC..CMD_HOLD), state enum (ST_RUN, ST_HALT, ST_ERR), default AW.
- Sub-module `ras_stack`: DEPTH×AW LIFO.
  - Inputs: push, pop, din. Outputs: top, sp, full, empty.
  - Same clock and async reset.
  - Instantiated only under `PC_SEQ_STACK_EN`.

## Test plan
- Reset, then INC ×3 from `pc_cur`=0x00 → `pc_next` 0x01, 0x02, 0x03; `halted`=0, `err`=0.
- `pc_cur`=0xFF, INC → `pc_next`=0x00. BZ `target`=0x40: with `zflag`=1 → 0x40; with `zflag`=0 → `pc_cur`+1.
- CALL 0x80 at `pc_cur`=0x10 → `pc_next`=0x80, `sp`=1. RET next cycle → `pc_next`=0x11, `sp`=0. Nested CALLs to depth 4 return in LIFO order.
- Fifth CALL with DEPTH=4 → `pc_next`=`pc_cur`, `err`=1. RET with `sp`=0 → `err`=1. `err` holds until `rst`.
- HALT → `halted`=1, `pc_next` stays `pc_cur` with JMP applied. `resume`=1 with `stall`=1 → no change. `resume`=1 with `stall`=0 → RUN next cycle.
- `stall`=1 with CALL 0x20 → `pc_next`=`pc_cur`, `sp` unchanged. Assert `rst` mid-CALL sequence → `sp`=0 and `pc_next`=0 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - CMD_* : encoding of the 3-bit command bus from the decoder
//   - state_e : run/halt/error state of the sequencer
//   - DEFAULT_AW : default PC address width
package pc_seq_pkg;

  localparam int unsigned DEFAULT_AW = 8;

  localparam logic [2:0] CMD_INC  = 3'd0;
  localparam logic [2:0] CMD_JMP  = 3'd1;
  localparam logic [2:0] CMD_BZ   = 3'd2;
  localparam logic [2:0] CMD_BNZ  = 3'd3;
  localparam logic [2:0] CMD_CALL = 3'd4;
  localparam logic [2:0] CMD_RET  = 3'd5;
  localparam logic [2:0] CMD_HALT = 3'd6;
  localparam logic [2:0] CMD_HOLD = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: DEPTH x AW LIFO.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears occupancy only)
//   push, pop  : push din / pop top; push is ignored when full, pop when empty
//   din        : value to push
//   top        : most recently pushed entry (undefined when empty)
//   sp         : current occupancy, 0..DEPTH
//   full/empty : occupancy flags
module ras_stack #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                din,
  output logic [AW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  wr_idx, rd_idx;
  logic           do_push, do_pop;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push & ~full;
  // Push wins if both are requested; the sequencer never issues both.
  assign do_pop  = pop & ~empty & ~push;

  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - SPW'(1));
  assign top    = mem_q[rd_idx];
  assign sp     = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents need no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter register.
// Selects pc_next (PC register PCin) each cycle from INC/JMP/BZ/BNZ/CALL/RET/HALT/HOLD,
// owns the run/halt/error state machine and, optionally, a return-address stack.
// Build option: define PC_SEQ_STACK_EN to instantiate the return stack; without it
// CALL behaves as JMP, RET as INC, sp and err are tied to 0.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   pc_cur        : current PC (PC register PCout)
//   cmd_valid/cmd : command and its qualifier (invalid cycles act as INC)
//   target        : jump/branch/call destination
//   zflag         : ALU zero flag for BZ/BNZ
//   stall         : freeze PC and all internal state
//   resume        : leave HALT
//   pc_next       : combinational next PC
//   halted, err   : state decodes
//   sp            : return stack occupancy
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              pc_cur,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic [AW-1:0]              target,
  input  logic                       zflag,
  input  logic                       stall,
  input  logic                       resume,
  output logic [AW-1:0]              pc_next,
  output logic                       halted,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] sp
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_inc;
  logic [2:0]    cmd_eff;

  assign pc_inc  = pc_cur + AW'(1);
  assign cmd_eff = cmd_valid ? cmd : CMD_INC;

`ifdef PC_SEQ_STACK_EN
  logic          push, pop, full, empty;
  logic [AW-1:0] top;

  ras_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  assign err = (state_q == ST_ERR);
`else
  assign sp  = '0;
  assign err = 1'b0;
`endif

  assign halted = (state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    pc_next = pc_cur;
`ifdef PC_SEQ_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          case (cmd_eff)
            CMD_INC: pc_next = pc_inc;
            CMD_JMP: pc_next = target;
            CMD_BZ:  pc_next = zflag ? target : pc_inc;
            CMD_BNZ: pc_next = zflag ? pc_inc : target;
`ifdef PC_SEQ_STACK_EN
            CMD_CALL: begin
              if (full) begin
                state_d = ST_ERR;
              end else begin
                push    = 1'b1;
                pc_next = target;
              end
            end
            CMD_RET: begin
              if (empty) begin
                state_d = ST_ERR;
              end else begin
                pop     = 1'b1;
                pc_next = top;
              end
            end
`else
            CMD_CALL: pc_next = target;
            CMD_RET:  pc_next = pc_inc;
`endif
            CMD_HALT: state_d = ST_HALT;
            default:  ; // HOLD: keep PC and state
          endcase
        end
      end
      ST_HALT: begin
        if (resume && !stall) begin
          state_d = ST_RUN;
        end
      end
      ST_ERR:  ; // sticky until reset
      default: state_d = ST_RUN;
    endcase
    // Reset forces a zero PC while asserted, independent of the register state.
    if (rst) begin
      pc_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

`ifdef PC_SEQ_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc_cur = '0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = '0;
  logic [AW-1:0] target = '0;
  logic          zflag = 1'b0;
  logic          stall = 1'b0;
  logic          resume = 1'b0;
  logic [AW-1:0] pc_next;
  logic          halted;
  logic          err;
  logic [2:0]    sp;

  pc_sequencer #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_cur    (pc_cur),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .target    (target),
    .zflag     (zflag),
    .stall     (stall),
    .resume    (resume),
    .pc_next   (pc_next),
    .halted    (halted),
    .err       (err),
    .sp        (sp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic       halted;
    logic       err;
    logic [2:0] sp;
    string      tag;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         passes = 0;

  // Reference model: 0 = running, 1 = halted, 2 = error; stack as a queue.
  int         m_st = 0;
  logic [7:0] m_stk[$];
  logic [7:0] nxt_pc = '0;

  // Apply one cycle of stimulus and predict the visible response for that cycle.
  task automatic step(input logic r, input logic [7:0] pc, input logic v, input logic [2:0] c,
                      input logic [7:0] tg, input logic z, input logic s, input logic rs,
                      input string tag);
    exp_t       e;
    logic [7:0] inc;
    logic [2:0] ce;
    @(posedge clk);
    #1;
    rst = r; pc_cur = pc; cmd_valid = v; cmd = c; target = tg; zflag = z; stall = s;
    resume = rs;
    e.tag = tag;
    if (r) begin
      m_st = 0;
      m_stk.delete();
      e.pc = 8'h00; e.halted = 1'b0; e.err = 1'b0; e.sp = 3'd0;
    end else begin
      inc = pc + 8'd1;
      e.pc = pc;
      e.halted = (m_st == 1);
      e.err = (m_st == 2);
      e.sp = 3'(m_stk.size());
      if (m_st == 0 && !s) begin
        ce = v ? c : CMD_INC;
        if (ce == CMD_INC) e.pc = inc;
        else if (ce == CMD_JMP) e.pc = tg;
        else if (ce == CMD_BZ) e.pc = z ? tg : inc;
        else if (ce == CMD_BNZ) e.pc = z ? inc : tg;
        else if (ce == CMD_CALL) begin
          if (!STACK) e.pc = tg;
          else if (m_stk.size() == DEPTH) m_st = 2;
          else begin m_stk.push_back(inc); e.pc = tg; end
        end else if (ce == CMD_RET) begin
          if (!STACK) e.pc = inc;
          else if (m_stk.size() == 0) m_st = 2;
          else e.pc = m_stk.pop_back();
        end else if (ce == CMD_HALT) m_st = 1;
      end else if (m_st == 1 && rs && !s) begin
        m_st = 0;
      end
    end
    nxt_pc = e.pc;
    expq.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (pc_next === e.pc && halted === e.halted && err === e.err && sp === e.sp) begin
        passes++;
      end else begin
        $display("FAIL %s: got pc_next=%h halted=%b err=%b sp=%0d, want pc_next=%h halted=%b err=%b sp=%0d",
                 e.tag, pc_next, halted, err, sp, e.pc, e.halted, e.err, e.sp);
      end
    end
  end

  initial begin
    #3 rst = 1'b1;
    step(1, 8'h00, 0, CMD_INC, 8'h00, 0, 0, 0, "reset");
    step(1, 8'h55, 1, CMD_JMP, 8'h99, 0, 0, 0, "reset_hold");
    // Sequential increment and wrap
    step(0, 8'h00, 1, CMD_INC, 8'h00, 0, 0, 0, "inc0");
    step(0, 8'h01, 1, CMD_INC, 8'h00, 0, 0, 0, "inc1");
    step(0, 8'h02, 1, CMD_INC, 8'h00, 0, 0, 0, "inc2");
    step(0, 8'hFF, 1, CMD_INC, 8'h00, 0, 0, 0, "inc_wrap");
    step(0, 8'h05, 0, CMD_JMP, 8'hAA, 0, 0, 0, "invalid_is_inc");
    step(0, 8'h07, 1, CMD_BZ, 8'h40, 1, 0, 0, "bz_taken");
    step(0, 8'h07, 1, CMD_BZ, 8'h40, 0, 0, 0, "bz_not_taken");
    step(0, 8'h09, 1, CMD_BNZ, 8'h44, 0, 0, 0, "bnz_taken");
    step(0, 8'h09, 1, CMD_BNZ, 8'h44, 1, 0, 0, "bnz_not_taken");
    step(0, 8'h0A, 1, CMD_HOLD, 8'h44, 1, 0, 0, "hold");
    // Call / return
    step(0, 8'h10, 1, CMD_CALL, 8'h80, 0, 0, 0, "call");
    step(0, 8'h80, 1, CMD_RET, 8'h00, 0, 0, 0, "ret");
    step(0, 8'h11, 1, CMD_INC, 8'h00, 0, 0, 0, "after_ret");
    for (int i = 0; i < 4; i++)
      step(0, 8'(32 + 16 * i), 1, CMD_CALL, 8'(40 + 16 * i), 0, 0, 0, "nest_call");
    step(0, 8'h70, 1, CMD_INC, 8'h00, 0, 0, 0, "nest_sp4");
    for (int i = 0; i < 4; i++)
      step(0, 8'(200 + i), 1, CMD_RET, 8'h00, 0, 0, 0, "nest_ret");
    // Overflow
    for (int i = 0; i < 5; i++)
      step(0, 8'(96 + i), 1, CMD_CALL, 8'hC0, 0, 0, 0, "ovf_call");
    step(0, 8'h33, 1, CMD_JMP, 8'h12, 0, 0, 0, "err_sticky");
    step(0, 8'h34, 1, CMD_RET, 8'h12, 0, 0, 1, "err_sticky2");
    step(1, 8'h34, 1, CMD_INC, 8'h00, 0, 0, 0, "err_reset");
    // Underflow
    step(0, 8'h20, 1, CMD_RET, 8'h00, 0, 0, 0, "ret_empty");
    step(0, 8'h20, 1, CMD_INC, 8'h00, 0, 0, 0, "ret_empty_err");
    step(1, 8'h20, 1, CMD_INC, 8'h00, 0, 0, 0, "udf_reset");
    // Halt / resume
    step(0, 8'h30, 1, CMD_HALT, 8'h00, 0, 0, 0, "halt");
    step(0, 8'h30, 1, CMD_JMP, 8'h77, 0, 0, 0, "halt_ignores_jmp");
    step(0, 8'h30, 1, CMD_JMP, 8'h77, 0, 1, 1, "resume_stalled");
    step(0, 8'h30, 1, CMD_JMP, 8'h77, 0, 0, 1, "resume");
    step(0, 8'h30, 1, CMD_JMP, 8'h77, 0, 0, 0, "first_run_cmd");
    // Stall beats command
    step(0, 8'h50, 1, CMD_CALL, 8'h20, 0, 1, 0, "stall_call");
    step(0, 8'h50, 1, CMD_INC, 8'h20, 0, 0, 0, "after_stall");
    // Reset mid call sequence
    step(0, 8'h60, 1, CMD_CALL, 8'h61, 0, 0, 0, "pre_rst_call1");
    step(0, 8'h61, 1, CMD_CALL, 8'h62, 0, 0, 0, "pre_rst_call2");
    step(1, 8'h62, 1, CMD_CALL, 8'h63, 0, 0, 0, "mid_reset");
    step(0, 8'h00, 1, CMD_INC, 8'h00, 0, 0, 0, "post_reset");
    // Randomized run with the PC fed back from the predicted next address
    for (int i = 0; i < 400; i++) begin
      logic       r, v, z, s, rs;
      logic [7:0] pc, tg;
      logic [2:0] c;
      r  = ($urandom_range(0, 99) < 3);
      pc = ($urandom_range(0, 7) == 0) ? 8'($urandom) : nxt_pc;
      v  = ($urandom_range(0, 99) < 85);
      c  = 3'($urandom);
      tg = 8'($urandom);
      z  = 1'($urandom);
      s  = ($urandom_range(0, 99) < 10);
      rs = ($urandom_range(0, 99) < 25);
      step(r, pc, v, c, tg, z, s, rs, "random");
    end
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
